// File: rtl/datapath_scheduler.sv
// datapath_scheduler: round-robin sharing of one sequenced datapath among N_REQ requesters, with watchdog abort
module datapath_scheduler #(
    parameter int N_REQ = 4,
    parameter int DATA_W = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic [DATA_W-1:0]       result,
    output logic                    busy,
    output logic                    dp_start,
    output logic                    dp_rst,
    output logic [DATA_W-1:0]       dp_x,
    input  logic                    dp_finished,
    input  logic [DATA_W-1:0]       dp_result
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, CAPTURE, ABORT, CLEAR} state_t;
    state_t state, state_n;
    logic [IW-1:0] ptr, owner, pick, cand;
    logic [WW-1:0] wdog;
    logic found, rst_q;
    always_comb begin
        found = 1'b0;
        pick = ptr;
        cand = ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick = cand;
            end
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? LAUNCH : IDLE;
            LAUNCH:  state_n = RUN;
            RUN:     state_n = dp_finished ? CAPTURE : (wdog == WW'(TIMEOUT - 1)) ? ABORT : RUN;
            CAPTURE: state_n = CLEAR;
            ABORT:   state_n = CLEAR;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
            ptr <= IW'(N_REQ - 1);
            owner <= '0;
            dp_x <= '0;
            result <= '0;
            wdog <= '0;
            rst_q <= 1'b1;
        end else begin
            state <= state_n;
            rst_q <= 1'b0;
            if (state == IDLE && found) begin
                owner <= pick;
                dp_x <= req_data[int'(pick)*DATA_W +: DATA_W];
            end
            wdog <= state == LAUNCH ? '0 : state == RUN ? wdog + 1'b1 : wdog;
            // result is taken on entry to CAPTURE so it is valid alongside the done pulse
            if (state == RUN && dp_finished) result <= dp_result;
            if (state == CAPTURE || state == ABORT) ptr <= owner;
        end
    end
    assign busy = state != IDLE;
    assign grant = busy ? {{(N_REQ-1){1'b0}}, 1'b1} << owner : '0;
    assign done = state == CAPTURE ? grant : '0;
    assign err = state == ABORT ? grant : '0;
    assign dp_start = state == LAUNCH;
    assign dp_rst = RST | rst_q | (state == CLEAR);
endmodule

// File: tb/tb_datapath_scheduler.sv
// tb_datapath_scheduler: directed checks of arbitration, latency, watchdog and reset behaviour
module tb_datapath_scheduler;
    localparam int TIMEOUT = 15;
    localparam logic [15:0] M = 16'h1231;
    logic clk = 1'b0, RST = 1'b0, dp_finished = 1'b0;
    logic [3:0] req = '0, grant, done, err;
    logic [63:0] req_data;
    logic [15:0] result, dp_x, dp_result, last_res;
    logic busy, dp_start, dp_rst;
    logic [15:0] d [4];
    int checks = 0, errors = 0;
    datapath_scheduler #(.N_REQ(4), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .RST(RST), .req(req), .req_data(req_data), .grant(grant), .done(done),
        .err(err), .result(result), .busy(busy), .dp_start(dp_start), .dp_rst(dp_rst),
        .dp_x(dp_x), .dp_finished(dp_finished), .dp_result(dp_result)
    );
    always #5 clk = ~clk;
    assign dp_result = dp_x ^ M;
    assign req_data = {d[3], d[2], d[1], d[0]};
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic do_reset();
        RST = 1'b1;
        req = '0;
        dp_finished = 1'b0;
        tick();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", dp_start, 0);
        chk("rst_x", dp_x, 0);
        chk("rst_dprst", dp_rst, 1);
        RST = 1'b0;
        chk("rst_dprst_after", dp_rst, 1);
        tick();
        chk("rst_dprst_end", dp_rst, 0);
        last_res = '0;
    endtask
    // one job from IDLE: finishes in RUN cycle k when fin, otherwise left to the watchdog
    task automatic job(input string tag, input logic [3:0] g, input logic [15:0] x, input int k,
                       input bit fin, input logic [3:0] mreq);
        int n = 0;
        while (!dp_start && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 1);
        chk({tag, "_grant"}, grant, g);
        chk({tag, "_x"}, dp_x, x);
        chk({tag, "_busy"}, busy, 1);
        tick();
        req = mreq;
        chk({tag, "_start_once"}, dp_start, 0);
        for (int i = 1; i < (fin ? k : TIMEOUT); i++) tick();
        chk({tag, "_no_early_end"}, {done, err}, 0);
        if (fin) dp_finished = 1'b1;
        tick();
        if (fin) begin
            last_res = x ^ M;
            chk({tag, "_done"}, done, g);
            chk({tag, "_noerr"}, err, 0);
        end else begin
            chk({tag, "_err"}, err, g);
            chk({tag, "_nodone"}, done, 0);
        end
        chk({tag, "_result"}, result, last_res);
        chk({tag, "_x_hold"}, dp_x, x);
        tick();
        chk({tag, "_clr_dprst"}, dp_rst, 1);
        chk({tag, "_clr_grant"}, grant, g);
        chk({tag, "_clr_pulse"}, {done, err}, 0);
        dp_finished = 1'b0;
        tick();
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_grant"}, grant, 0);
        chk({tag, "_idle_dprst"}, dp_rst, 0);
    endtask
    initial begin
        d[0] = 16'h0005;
        d[1] = 16'hB002;
        d[2] = 16'hC003;
        d[3] = 16'hD004;
        do_reset();
        req = 4'b0001;
        job("t1", 4'b0001, d[0], 7, 1'b1, 4'b0001);
        chk("t1_result_val", result, 16'h1234);
        req = '0;
        do_reset();
        req = 4'b1111;
        job("t2_a", 4'b0001, d[0], 3, 1'b1, 4'b1111);
        job("t2_b", 4'b0010, d[1], 2, 1'b1, 4'b1111);
        job("t2_c", 4'b0100, d[2], 5, 1'b1, 4'b1111);
        job("t2_d", 4'b1000, d[3], 1, 1'b1, 4'b1111);
        job("t2_e", 4'b0001, d[0], 4, 1'b1, 4'b1111);
        job("t3", 4'b0010, d[1], 0, 1'b0, 4'b1111);
        job("t4", 4'b0100, d[2], TIMEOUT, 1'b1, 4'b1111);
        job("t6_a", 4'b1000, d[3], 4, 1'b1, 4'b0100);
        job("t6_b", 4'b0100, d[2], 2, 1'b1, 4'b0100);
        req = 4'b1000;
        tick();
        chk("t5_start", dp_start, 1);
        chk("t5_grant", grant, 4'b1000);
        tick();
        tick();
        RST = 1'b1;
        tick();
        chk("t5_grant0", grant, 0);
        chk("t5_pulse0", {done, err}, 0);
        chk("t5_busy0", busy, 0);
        chk("t5_start0", dp_start, 0);
        chk("t5_x0", dp_x, 0);
        chk("t5_result0", result, 0);
        chk("t5_dprst", dp_rst, 1);
        RST = 1'b0;
        last_res = '0;
        req = 4'b1100;
        chk("t5_dprst_after", dp_rst, 1);
        job("t5_ptr", 4'b0100, d[2], 3, 1'b1, 4'b1100);
        req = '0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
